// File: rtl/burst_pkg.sv
// Shared types and helpers for the burst write arbiter.
// Grant-order entries and the round-robin search live here.
package burst_pkg;

    localparam int LEN_W = 8;
    localparam int MAX_M = 8;
    localparam int ID_W  = 3;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] length;
    } order_entry_t;

    // First requester after 'last', wrapping over n masters.
    function automatic logic [ID_W-1:0] rr_next(
        input logic [MAX_M-1:0] req,
        input logic [ID_W-1:0]  last,
        input int               n
    );
        int   k;
        logic found;
        rr_next = last;
        found   = 1'b0;
        for (int i = 1; i <= MAX_M; i++) begin
            k = (int'(last) + i) % n;
            if (i <= n && !found && req[k[ID_W-1:0]]) begin
                rr_next = k[ID_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/burst_order_fifo.sv
// Grant-order FIFO: remembers which master owns each burst
// so response beats can be routed back in issue order.
module burst_order_fifo
    import burst_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  order_entry_t push_data,
    input  logic         pop,
    output order_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    order_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/burst_write_arbiter.sv
// Round-robin arbiter sharing one burst write pipeline;
// data is locked to the granted master until its last beat.
module burst_write_arbiter
    import burst_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_MASTERS = 2,
    parameter int ORDER_DEPTH = 4,
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_addr,
    input  logic [NUM_MASTERS*LEN_W-1:0]      s_length,
    input  logic [NUM_MASTERS-1:0]            s_addr_valid,
    output logic [NUM_MASTERS-1:0]            s_addr_ready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_MASTERS-1:0]            s_data_valid,
    output logic [NUM_MASTERS-1:0]            s_data_ready,
    output logic [ADDR_WIDTH-1:0]             s_response,
    output logic [NUM_MASTERS-1:0]            s_resp_valid,
    input  logic [NUM_MASTERS-1:0]            s_resp_ready,
    output logic [ADDR_WIDTH-1:0]             m_addr,
    output logic [LEN_W-1:0]                  m_length,
    output logic                              m_addr_valid,
    input  logic                              m_addr_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              m_data_valid,
    input  logic                              m_data_ready,
    input  logic [ADDR_WIDTH-1:0]             m_response,
    input  logic                              m_resp_valid,
    output logic                              m_resp_ready,
    output logic [GW-1:0]                     grant_id,
    output logic                              busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] rcnt;
    logic [GW-1:0]   g;
    logic [GW-1:0]   h;
    logic [ID_W-1:0] rr_pick;
    order_entry_t    head;
    order_entry_t    push_entry;
    logic            full;
    logic            empty;
    logic            addr_hs;
    logic            data_hs;
    logic            resp_hs;
    logic            pop;
    logic            unused;

    assign g = grant_id;
    assign h = head.id[GW-1:0];
    assign unused = &{1'b0, head.id, rr_pick};

    assign m_addr       = s_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_length     = s_length[g*LEN_W +: LEN_W];
    assign m_addr_valid = (state == ADDR) && s_addr_valid[g];
    assign m_data       = s_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign m_data_valid = (state == DATA) && s_data_valid[g];
    assign busy         = (state != IDLE);

    assign addr_hs = m_addr_valid && m_addr_ready;
    assign data_hs = m_data_valid && m_data_ready;

    assign m_resp_ready = !empty && s_resp_ready[h];
    assign s_response   = m_response;
    assign resp_hs      = m_resp_valid && m_resp_ready;
    assign pop          = resp_hs && (rcnt == head.length);

    assign rr_pick = rr_next(MAX_M'(s_addr_valid), ID_W'(last_grant),
                             NUM_MASTERS);

    assign push_entry = '{id: ID_W'(g), length: m_length};

    always_comb begin
        s_addr_ready = '0;
        s_data_ready = '0;
        s_resp_valid = '0;
        if (state == ADDR)
            s_addr_ready[g] = m_addr_ready;
        if (state == DATA)
            s_data_ready[g] = m_data_ready;
        if (!empty)
            s_resp_valid[h] = m_resp_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_MASTERS - 1);
            beat_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|s_addr_valid && !full) begin
                        grant_id <= rr_pick[GW-1:0];
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (addr_hs) begin
                        beat_cnt <= m_length;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (data_hs) begin
                        if (beat_cnt == '0) begin
                            last_grant <= grant_id;
                            state      <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response beats are counted per head entry; the last one retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rcnt <= '0;
        else if (resp_hs)
            rcnt <= pop ? '0 : rcnt + 1'b1;
    end

    burst_order_fifo #(
        .DEPTH (ORDER_DEPTH)
    ) u_order (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (addr_hs),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_burst_write_arbiter.sv
// Directed bench for burst_write_arbiter: bench models two masters
// and the downstream pipeline (response = written data word).
module tb_burst_write_arbiter;

    localparam int NM = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NM*AW-1:0] s_addr;
    logic [NM*8-1:0]  s_length;
    logic [NM-1:0]    s_addr_valid;
    logic [NM-1:0]    s_addr_ready;
    logic [NM*DW-1:0] s_data;
    logic [NM-1:0]    s_data_valid;
    logic [NM-1:0]    s_data_ready;
    logic [AW-1:0]    s_response;
    logic [NM-1:0]    s_resp_valid;
    logic [NM-1:0]    s_resp_ready;
    logic [AW-1:0]    m_addr;
    logic [7:0]       m_length;
    logic             m_addr_valid;
    logic             m_addr_ready;
    logic [DW-1:0]    m_data;
    logic             m_data_valid;
    logic             m_data_ready;
    logic [AW-1:0]    m_response;
    logic             m_resp_valid;
    logic             m_resp_ready;
    logic [0:0]       grant_id;
    logic             busy;

    always #5 clk = ~clk;

    burst_write_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .NUM_MASTERS (NM),
        .ORDER_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_addr       (s_addr),
        .s_length     (s_length),
        .s_addr_valid (s_addr_valid),
        .s_addr_ready (s_addr_ready),
        .s_data       (s_data),
        .s_data_valid (s_data_valid),
        .s_data_ready (s_data_ready),
        .s_response   (s_response),
        .s_resp_valid (s_resp_valid),
        .s_resp_ready (s_resp_ready),
        .m_addr       (m_addr),
        .m_length     (m_length),
        .m_addr_valid (m_addr_valid),
        .m_addr_ready (m_addr_ready),
        .m_data       (m_data),
        .m_data_valid (m_data_valid),
        .m_data_ready (m_data_ready),
        .m_response   (m_response),
        .m_resp_valid (m_resp_valid),
        .m_resp_ready (m_resp_ready),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;

    int          n_b [NM];
    logic [31:0] b_addr [NM][8];
    logic [7:0]  b_len [NM][8];
    int          ai [NM];
    int          di [NM];
    int          beat [NM];
    logic [NM-1:0] rrdy;
    bit          stall;

    logic [31:0] rq [$];
    logic [31:0] addr_log [$];
    logic [31:0] len_log [$];
    logic [31:0] gid_log [$];
    logic [31:0] data_log [$];
    logic [31:0] resp0 [$];
    logic [31:0] resp1 [$];
    int          viol_gid;
    int          viol_early;
    int          viol_hot;
    logic [0:0]  prev_gid;
    logic        prev_busy;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int m = 0; m < NM; m++) begin
            n_b[m]  = 0;
            ai[m]   = 0;
            di[m]   = 0;
            beat[m] = 0;
        end
        rq.delete();
        addr_log.delete();
        len_log.delete();
        gid_log.delete();
        data_log.delete();
        resp0.delete();
        resp1.delete();
        prev_busy = 1'b0;
        prev_gid  = 1'b0;
    endtask

    task automatic add_burst(input int m, input logic [31:0] a,
                             input logic [7:0] l);
        b_addr[m][n_b[m]] = a;
        b_len[m][n_b[m]]  = l;
        n_b[m]++;
    endtask

    task automatic drive();
        for (int m = 0; m < NM; m++) begin
            s_addr_valid[m] = ai[m] < n_b[m];
            s_addr[m*AW +: AW] = (ai[m] < n_b[m]) ? b_addr[m][ai[m]] : '0;
            s_length[m*8 +: 8] = (ai[m] < n_b[m]) ? b_len[m][ai[m]] : '0;
            s_data_valid[m] = di[m] < n_b[m];
            s_data[m*DW +: DW] = (di[m] < n_b[m]) ?
                b_addr[m][di[m]] + 32'(beat[m]) : '0;
        end
        m_addr_ready = 1'b1;
        m_data_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_resp_valid = rq.size() > 0;
        m_response   = (rq.size() > 0) ? rq[0] : '0;
        s_resp_ready = rrdy;
    endtask

    task automatic tick();
        bit ahs [NM];
        bit dhs [NM];
        @(negedge clk);
        for (int m = 0; m < NM; m++) begin
            ahs[m] = s_addr_valid[m] && s_addr_ready[m];
            dhs[m] = s_data_valid[m] && s_data_ready[m];
            if (s_data_ready[m] && ai[m] <= di[m])
                viol_early++;
        end
        if (m_addr_valid && m_addr_ready) begin
            addr_log.push_back(m_addr);
            len_log.push_back(32'(m_length));
            gid_log.push_back(32'(grant_id));
        end
        if (m_resp_valid && m_resp_ready)
            void'(rq.pop_front());
        if (s_resp_valid[0] && s_resp_ready[0])
            resp0.push_back(s_response);
        if (s_resp_valid[1] && s_resp_ready[1])
            resp1.push_back(s_response);
        if (s_resp_valid == 2'b11)
            viol_hot++;
        if (m_data_valid && m_data_ready) begin
            data_log.push_back(m_data);
            rq.push_back(m_data);
        end
        if (grant_id != prev_gid && prev_busy)
            viol_gid++;
        prev_gid  = grant_id;
        prev_busy = busy;
        @(posedge clk);
        #1;
        for (int m = 0; m < NM; m++) begin
            if (ahs[m])
                ai[m]++;
            if (dhs[m]) begin
                if (beat[m] == int'(b_len[m][di[m]])) begin
                    beat[m] = 0;
                    di[m]++;
                end else begin
                    beat[m]++;
                end
            end
        end
        drive();
    endtask

    function automatic bit all_done();
        all_done = (rq.size() == 0) && !busy;
        for (int m = 0; m < NM; m++)
            if (ai[m] < n_b[m] || di[m] < n_b[m])
                all_done = 1'b0;
    endfunction

    task automatic run_done(input string tag, input int budget);
        int c = 0;
        while (!all_done() && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_timeout"}, 32'(all_done()), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        drive();
        repeat (2) tick();
        clear_model();
        rst_n = 1'b1;
    endtask

    logic [31:0] exp_d [8];

    initial begin
        viol_gid   = 0;
        viol_early = 0;
        viol_hot   = 0;
        stall      = 1'b0;
        rrdy       = 2'b11;
        rst_n      = 1'b0;
        clear_model();
        add_burst(0, 32'h40, 8'd3);
        drive();
        repeat (2) tick();
        // inputs are already valid, outputs must stay quiet in reset
        check("rst_addr_ready", 32'(s_addr_ready), 32'd0);
        check("rst_data_ready", 32'(s_data_ready), 32'd0);
        check("rst_m_addr_valid", 32'(m_addr_valid), 32'd0);
        check("rst_m_data_valid", 32'(m_data_valid), 32'd0);
        check("rst_m_resp_ready", 32'(m_resp_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);

        // S1: single master, 4-beat burst
        tick();
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_grant", 32'(grant_id), 32'd0);
        check("s1_addr_ready", 32'(s_addr_ready), 32'b01);
        run_done("s1", 100);
        check("s1_naddr", addr_log.size(), 1);
        check("s1_addr", addr_log[0], 32'h40);
        check("s1_len", len_log[0], 32'd3);
        check("s1_ndata", data_log.size(), 4);
        check("s1_nresp0", resp0.size(), 4);
        check("s1_nresp1", resp1.size(), 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s1_data%0d", i), data_log[i], 32'h40 + 32'(i));
            check($sformatf("s1_resp%0d", i), resp0[i], 32'h40 + 32'(i));
        end

        // S2: both masters, 2 bursts each of length 1
        do_reset();
        add_burst(0, 32'h100, 8'd1);
        add_burst(0, 32'h200, 8'd1);
        add_burst(1, 32'h300, 8'd1);
        add_burst(1, 32'h400, 8'd1);
        drive();
        run_done("s2", 200);
        check("s2_ngrant", gid_log.size(), 4);
        check("s2_g0", gid_log[0], 32'd0);
        check("s2_g1", gid_log[1], 32'd1);
        check("s2_g2", gid_log[2], 32'd0);
        check("s2_g3", gid_log[3], 32'd1);
        exp_d = '{32'h100, 32'h101, 32'h300, 32'h301,
                  32'h200, 32'h201, 32'h400, 32'h401};
        check("s2_ndata", data_log.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("s2_data%0d", i), data_log[i], exp_d[i]);
        check("s2_nresp0", resp0.size(), 4);
        check("s2_nresp1", resp1.size(), 4);
        check("s2_resp0_2", resp0[2], 32'h200);
        check("s2_resp1_3", resp1[3], 32'h401);

        // S3: master 1 offers data early while master 0 bursts
        do_reset();
        add_burst(0, 32'h40, 8'd3);
        add_burst(1, 32'h100, 8'd0);
        drive();
        run_done("s3", 100);
        check("s3_ndata", data_log.size(), 5);
        check("s3_data3", data_log[3], 32'h43);
        check("s3_data4", data_log[4], 32'h100);
        check("s3_resp1", resp1.size(), 1);

        // S4: order FIFO fills while responses are held off
        do_reset();
        rrdy = 2'b00;
        for (int i = 0; i < 6; i++)
            add_burst(0, 32'h500 + 32'(i), 8'd0);
        drive();
        repeat (40) tick();
        check("s4_ngrant_full", addr_log.size(), 4);
        check("s4_busy_full", 32'(busy), 32'd0);
        check("s4_m_addr_valid", 32'(m_addr_valid), 32'd0);
        rrdy = 2'b01;
        drive();
        tick();
        rrdy = 2'b00;
        drive();
        repeat (8) tick();
        check("s4_ngrant_pop", addr_log.size(), 5);
        check("s4_addr5", addr_log[4], 32'h504);
        check("s4_nresp_pop", resp0.size(), 1);
        check("s4_busy_refull", 32'(busy), 32'd0);
        rrdy = 2'b11;
        drive();
        run_done("s4", 200);
        check("s4_nresp0", resp0.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("s4_resp%0d", i), resp0[i], 32'h500 + 32'(i));

        // S5: reset at the second beat of a 4-beat burst
        do_reset();
        add_burst(0, 32'h40, 8'd3);
        drive();
        for (int c = 0; c < 20 && data_log.size() < 1; c++)
            tick();
        check("s5_first_beat", data_log.size(), 1);
        rst_n = 1'b0;
        #1;
        check("s5_data_ready", 32'(s_data_ready), 32'd0);
        check("s5_m_data_valid", 32'(m_data_valid), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_resp_valid", 32'(s_resp_valid), 32'd0);
        check("s5_m_resp_ready", 32'(m_resp_ready), 32'd0);
        do_reset();
        add_burst(0, 32'h700, 8'd0);
        add_burst(1, 32'h800, 8'd0);
        drive();
        run_done("s5", 100);
        check("s5_g0", gid_log[0], 32'd0);
        check("s5_nresp0", resp0.size(), 1);
        check("s5_nresp1", resp1.size(), 1);
        check("s5_resp0", resp0[0], 32'h700);
        check("s5_resp1", resp1[0], 32'h800);

        // S6: back-to-back single-beat bursts from master 1, stalls
        do_reset();
        stall = 1'b1;
        add_burst(1, 32'h900, 8'd0);
        add_burst(1, 32'hA00, 8'd0);
        add_burst(1, 32'hB00, 8'd0);
        drive();
        run_done("s6", 300);
        check("s6_ngrant", gid_log.size(), 3);
        check("s6_nresp0", resp0.size(), 0);
        check("s6_nresp1", resp1.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("s6_gid%0d", i), gid_log[i], 32'd1);
            check($sformatf("s6_resp%0d", i), resp1[i],
                  32'h900 + 32'(i) * 32'h100);
        end

        check("gid_change_in_idle", 32'(viol_gid), 32'd0);
        check("no_early_data_ready", 32'(viol_early), 32'd0);
        check("resp_valid_onehot", 32'(viol_hot), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/burst_write_arbiter.md
Name: burst_write_arbiter

Overview:
- Shares one burst write pipeline between NUM_MASTERS independent burst-write requesters.
- Arbitrates address requests round-robin and locks the data channel to the granted master until the burst's last beat.
- Records grant order so per-beat responses from the pipeline are routed back to the originating master.
- Sits between the requesters and the burst write pipeline's u_*/d_* interfaces.

Parameters:
- DATA_WIDTH, 32, data beat width in bits.
- ADDR_WIDTH, 32, address and response width in bits.
- NUM_MASTERS, 2, number of requesters (2..8).
- ORDER_DEPTH, 4, entries in the grant-order FIFO (power of 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master burst start address (master i in slice i)
- s_length  in  NUM_MASTERS*8  per-master burst length minus 1
- s_addr_valid  in  NUM_MASTERS  per-master address valid
- s_addr_ready  out  NUM_MASTERS  per-master address ready
- s_data  in  NUM_MASTERS*DATA_WIDTH  per-master write data
- s_data_valid  in  NUM_MASTERS  per-master data valid
- s_data_ready  out  NUM_MASTERS  per-master data ready
- s_response  out  ADDR_WIDTH  response, broadcast to all masters
- s_resp_valid  out  NUM_MASTERS  per-master response valid
- s_resp_ready  in  NUM_MASTERS  per-master response ready
- m_addr / m_length / m_addr_valid  out  ADDR_WIDTH / 8 / 1  to pipeline u_addr / u_length / u_addr_valid
- m_addr_ready  in  1  from pipeline u_addr_ready
- m_data / m_data_valid  out  DATA_WIDTH / 1  to pipeline u_data / u_data_valid
- m_data_ready  in  1  from pipeline u_data_ready
- m_response / m_resp_valid  in  ADDR_WIDTH / 1  from pipeline d_response / d_valid
- m_resp_ready  out  1  to pipeline d_ready
- grant_id  out  $clog2(NUM_MASTERS)  currently granted master
- busy  out  1  high in ADDR or DATA state

Behaviour:
- Reset (async, rst_n low): state IDLE; last_grant = NUM_MASTERS-1, so master 0 wins first; beat counters 0; order FIFO empty; grant_id 0.
- All valid/ready outputs are decoded from registered state, so they are 0 during and immediately after reset.
- Reset mid-burst abandons the burst and flushes the FIFO.
- State IDLE:
  - If any s_addr_valid is high and the FIFO is not full, register the grant as the first requester found searching from last_grant+1 with wrap; go to ADDR.
  - Arbitration latency is one cycle.
  - If the FIFO is full, no grant is made.
- State ADDR:
  - m_addr, m_length and m_addr_valid pass through combinationally from master g = grant_id.
  - s_addr_ready[g] = m_addr_ready; all other s_addr_ready are 0.
  - On handshake: beat_cnt <= s_length[g]; push {g, s_length[g]} into the FIFO; go to DATA.
- State DATA:
  - m_data and m_data_valid pass through from master g; s_data_ready[g] = m_data_ready; all others are 0.
  - Each handshake with beat_cnt != 0 decrements beat_cnt.
  - The handshake with beat_cnt == 0 is the last beat: last_grant <= g; go to IDLE.
- Non-granted masters always see ready 0 and may hold valid indefinitely.
- Data presented before the address grant is stalled, never dropped.
- Response path (independent of the write FSM):
  - When the FIFO is non-empty with head {h, len}: m_resp_ready = s_resp_ready[h]; s_resp_valid[h] = m_resp_valid; other s_resp_valid are 0; s_response = m_response.
  - Response beat counter rcnt starts at 0. On each response handshake: if rcnt == len, pop the head and set rcnt to 0; otherwise increment rcnt.
  - When the FIFO is empty, m_resp_ready = 0.
- FIFO:
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Full blocks the grant; a pop frees a slot, and a grant can occur in the next IDLE cycle.
- Pointers are $clog2(ORDER_DEPTH) bits wide and wrap naturally, with an extra bit for full/empty.
- s_length 8'hFF gives a 256-beat burst; the 8-bit counter handles it with no overflow.

Decomposition:
- Shared package burst_pkg:
  - LEN_W = 8.
  - typedef order_entry_t {id, length}.
  - Round-robin next-index function.
- Sub-module burst_order_fifo: a synchronous FIFO of order_entry_t, depth ORDER_DEPTH, with full/empty flags and async active-low reset.
- The arbiter FSM and response demux stay in the top module.

Test Plan:
- Master 0 only: addr 0x40, length 3, data 0x40..0x43; downstream always ready -> one m_addr handshake (0x40, 3); 4 data beats in order; return to IDLE; 4 responses 0x40..0x43 on s_resp_valid[0] only.
- Both masters valid from the first cycle after reset, 2 bursts each, length 1 -> grant order 0,1,0,1; grant_id changes only in IDLE.
- Master 1 asserts s_data_valid with 0x100 while master 0 is bursting -> s_data_ready[1] stays 0 until master 1's address handshake; no 0x100 beat appears early on m_data.
- All s_resp_ready low, ORDER_DEPTH 4, 6 single-beat bursts offered -> exactly 4 bursts are granted, then busy stays 0 with the FIFO full. Raising s_resp_ready[0] pops one entry and the 5th grant follows.
- Assert rst_n low at the 2nd beat of a 4-beat burst -> all ready/valid outputs 0 immediately. After release, the FIFO is empty and master 0 is granted first.
- Back-to-back length-0 bursts from master 1 with random m_data_ready stalls (0-2 cycles) -> each burst is ADDR -> DATA -> IDLE; every response is routed to master 1 in order.
